// File: rtl/alu_sequencer.sv
// alu_sequencer: collects A, B and a one-hot op from button presses, fires an external ALU for one cycle and holds the result until acknowledged
//   params : N            operand/result width (>= 1)
//   inputs : clk, reset (sync, active-high), data_in[N], enter (level button), op_in[4] (level buttons),
//            clear (sync abort), alu_result[N] (combinational ALU output)
//   outputs: alu_a[N], alu_b[N], alu_op[4] (nonzero only in S_EXEC), result[N], result_valid,
//            state[3] (FSM code for LEDs), op_error (one-cycle pulse on an invalid op press)
//   macro  : ALU_SEQ_ACCUM_EN - acknowledging a result loads it into A and jumps to B entry
module alu_sequencer #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] data_in,
  input  logic         enter,
  input  logic [3:0]   op_in,
  input  logic         clear,
  input  logic [N-1:0] alu_result,
  output logic [N-1:0] alu_a,
  output logic [N-1:0] alu_b,
  output logic [3:0]   alu_op,
  output logic [N-1:0] result,
  output logic         result_valid,
  output logic [2:0]   state,
  output logic         op_error
);
  typedef enum logic [2:0] {
    S_A    = 3'd0,
    S_B    = 3'd1,
    S_OP   = 3'd2,
    S_EXEC = 3'd3,
    S_SHOW = 3'd4
  } state_t;
  state_t st;
  logic [N-1:0] reg_a, reg_b;
  logic [3:0] reg_op, op_prev;
  logic enter_prev;
  logic enter_evt, op_evt, op_ok;
  assign enter_evt = enter & ~enter_prev;
  assign op_evt = |(op_in & ~op_prev);
  assign op_ok = op_in == 4'b0001 || op_in == 4'b0010 || op_in == 4'b0100 || op_in == 4'b1000;
  assign alu_a = reg_a;
  assign alu_b = reg_b;
  assign alu_op = st == S_EXEC ? reg_op : 4'b0000;
  assign state = st;
  always_ff @(posedge clk) begin
    if (reset) begin
      st <= S_A;
      reg_a <= '0;
      reg_b <= '0;
      result <= '0;
      reg_op <= 4'b0000;
      result_valid <= 1'b0;
      op_error <= 1'b0;
      // buttons held through reset must not register as presses
      enter_prev <= 1'b1;
      op_prev <= 4'b1111;
    end else begin
      enter_prev <= enter;
      op_prev <= op_in;
      op_error <= 1'b0;
      if (clear) begin
        st <= S_A;
        result_valid <= 1'b0;
      end else begin
        case (st)
          S_A: if (enter_evt) begin
            reg_a <= data_in;
            st <= S_B;
          end
          S_B: if (enter_evt) begin
            reg_b <= data_in;
            st <= S_OP;
          end
          S_OP: if (op_evt) begin
            if (op_ok) begin
              reg_op <= op_in;
              st <= S_EXEC;
            end else op_error <= 1'b1;
          end
          S_EXEC: begin
            result <= alu_result;
            result_valid <= 1'b1;
            st <= S_SHOW;
          end
          S_SHOW: if (enter_evt) begin
            result_valid <= 1'b0;
`ifdef ALU_SEQ_ACCUM_EN
            reg_a <= result;
            st <= S_B;
`else
            st <= S_A;
`endif
          end
          default: st <= S_A;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: randomized and directed stimulus checked every cycle against a behavioural model of the sequencer
module tb_alu_sequencer;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [7:0] data_in = '0;
  logic enter = 1'b1;
  logic [3:0] op_in = 4'hF;
  logic clear = 1'b0;
  logic [7:0] alu_result;
  logic [7:0] alu_a, alu_b, result;
  logic [3:0] alu_op;
  logic result_valid, op_error;
  logic [2:0] state;
  int compared = 0;
  int mismatched = 0;

  alu_sequencer #(.N(8)) dut (
    .clk(clk), .reset(reset), .data_in(data_in), .enter(enter), .op_in(op_in),
    .clear(clear), .alu_result(alu_result), .alu_a(alu_a), .alu_b(alu_b),
    .alu_op(alu_op), .result(result), .result_valid(result_valid),
    .state(state), .op_error(op_error)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] alu_f(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op);
    return op == 4'b0001 ? a + b : op == 4'b0010 ? a - b : op == 4'b0100 ? a & b : op == 4'b1000 ? a | b : 8'h00;
  endfunction

  assign alu_result = alu_f(alu_a, alu_b, alu_op);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // behavioural model: phase 0..4 = collecting A, collecting B, awaiting op, executing, showing
  int ph;
  logic [7:0] m_a, m_b, m_res;
  logic [3:0] m_op, p_op;
  logic m_valid, m_err, p_en;
  bit m_known = 0;
  always @(posedge clk) begin
    bit ev_e, ev_o, good;
    ev_e = enter && !p_en;
    ev_o = (op_in & ~p_op) != 4'b0;
    good = op_in inside {4'b0001, 4'b0010, 4'b0100, 4'b1000};
    if (reset) begin
      ph = 0; m_a = 0; m_b = 0; m_res = 0; m_op = 0; m_valid = 0; m_err = 0;
      p_en = 1; p_op = 4'hF; m_known = 1;
    end else begin
      p_en = enter;
      p_op = op_in;
      m_err = 0;
      if (clear) begin
        ph = 0; m_valid = 0;
      end else if (ph == 0 && ev_e) begin
        m_a = data_in; ph = 1;
      end else if (ph == 1 && ev_e) begin
        m_b = data_in; ph = 2;
      end else if (ph == 2 && ev_o) begin
        if (good) begin m_op = op_in; ph = 3; end
        else m_err = 1;
      end else if (ph == 3) begin
        m_res = alu_f(m_a, m_b, m_op); m_valid = 1; ph = 4;
      end else if (ph == 4 && ev_e) begin
        m_valid = 0;
`ifdef ALU_SEQ_ACCUM_EN
        m_a = m_res; ph = 1;
`else
        ph = 0;
`endif
      end
    end
  end

  always @(negedge clk) if (m_known) begin
    check("state", 32'(state), 32'(ph));
    check("alu_a", 32'(alu_a), 32'(m_a));
    check("alu_b", 32'(alu_b), 32'(m_b));
    check("alu_op", 32'(alu_op), ph == 3 ? 32'(m_op) : 32'h0);
    check("result", 32'(result), 32'(m_res));
    check("result_valid", 32'(result_valid), 32'(m_valid));
    check("op_error", 32'(op_error), 32'(m_err));
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic press_enter(input logic [7:0] d);
    @(negedge clk) begin data_in = d; enter = 1; end
    @(negedge clk) enter = 0;
  endtask
  task automatic press_op(input logic [3:0] o);
    @(negedge clk) op_in = o;
    @(negedge clk) op_in = 0;
  endtask
  task automatic clr();
    @(negedge clk) clear = 1;
    @(negedge clk) clear = 0;
  endtask
  task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op, input logic [7:0] exp);
    clr();
    press_enter(a);
    press_enter(b);
    press_op(op);
    check("lit_alu_op_fire", 32'(alu_op), 32'(op));
    idle(1);
    check("lit_result", 32'(result), 32'(exp));
    check("lit_valid", 32'(result_valid), 32'h1);
    check("lit_state_show", 32'(state), 32'h4);
    check("lit_alu_op_idle", 32'(alu_op), 32'h0);
  endtask

  initial begin
    idle(3);
    reset = 0;
    idle(3);
    check("lit_held_enter_state", 32'(state), 32'h0);
    enter = 0;
    op_in = 0;
    idle(1);
    press_enter(8'h7A);
    check("lit_capture_a", 32'(alu_a), 32'h7A);
    check("lit_capture_state", 32'(state), 32'h1);
    do_op(8'h25, 8'h13, 4'b0001, 8'h38);
    do_op(8'h10, 8'h20, 4'b0010, 8'hF0);
    do_op(8'hF0, 8'h3C, 4'b0100, 8'h30);
    do_op(8'hF0, 8'h3C, 4'b1000, 8'hFC);
    // invalid op press, then a valid one
    clr();
    press_enter(8'h0F);
    press_enter(8'h30);
    @(negedge clk) op_in = 4'b0011;
    @(negedge clk);
    check("lit_op_error_pulse", 32'(op_error), 32'h1);
    check("lit_op_error_state", 32'(state), 32'h2);
    check("lit_op_error_alu_op", 32'(alu_op), 32'h0);
    @(negedge clk) op_in = 0;
    check("lit_op_error_once", 32'(op_error), 32'h0);
    press_op(4'b1000);
    idle(1);
    check("lit_after_error_result", 32'(result), 32'h3F);
    // events in the wrong states are ignored
    clr();
    press_op(4'b0001);
    check("lit_op_in_sa", 32'(state), 32'h0);
    press_enter(8'h01);
    press_op(4'b0001);
    check("lit_op_in_sb", 32'(state), 32'h1);
    press_enter(8'h02);
    press_enter(8'h99);
    check("lit_enter_in_sop", 32'(state), 32'h2);
    check("lit_enter_in_sop_b", 32'(alu_b), 32'h02);
    // clear aborts an S_EXEC cycle without touching result
    do_op(8'h25, 8'h13, 4'b0001, 8'h38);
    clr();
    press_enter(8'h11);
    press_enter(8'h22);
    @(negedge clk) op_in = 4'b0001;
    @(negedge clk) begin op_in = 0; clear = 1; end
    check("lit_exec_state", 32'(state), 32'h3);
    @(negedge clk) clear = 0;
    check("lit_abort_state", 32'(state), 32'h0);
    check("lit_abort_result", 32'(result), 32'h38);
    check("lit_abort_valid", 32'(result_valid), 32'h0);
    // acknowledging a result
    do_op(8'h05, 8'h03, 4'b0001, 8'h08);
    press_enter(8'h00);
`ifdef ALU_SEQ_ACCUM_EN
    check("lit_accum_state", 32'(state), 32'h1);
    check("lit_accum_a", 32'(alu_a), 32'h08);
    press_enter(8'h02);
    press_op(4'b0001);
    idle(1);
    check("lit_accum_result", 32'(result), 32'h0A);
`else
    check("lit_ack_state", 32'(state), 32'h0);
    check("lit_ack_valid", 32'(result_valid), 32'h0);
`endif
    // random traffic
    for (int i = 0; i < 2000; i++) begin
      int r;
      @(negedge clk);
      r = $urandom_range(0, 9);
      data_in = 8'($urandom);
      enter = $urandom_range(0, 2) == 0;
      op_in = r < 4 ? 4'(1 << r) : r == 4 ? 4'($urandom) : 4'b0000;
      clear = $urandom_range(0, 60) == 0;
      reset = $urandom_range(0, 300) == 0;
    end
    @(negedge clk) begin reset = 0; clear = 0; enter = 0; op_in = 0; end
    idle(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
